seg_scanner: RTL and testbench
==============================

SEG_SCANNER -- requirements
Module: seg_scanner

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 50000: clk cycles each digit stays lit (legal range >= 2).
REQ-002 SHALL provide clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL provide reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide nib_in  input  4  serial hex nibble stream; nibble 0 (LSB digit) presented first.
REQ-005 SHALL provide sync_in  input  1  high in the cycle nibble 0 is on nib_in.
REQ-006 SHALL provide seg_n  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-007 SHALL provide an_n  output  4  active-low one-hot digit enable; bit k lights digit k.
REQ-008 SHALL provide frame_valid  output  1  one-cycle pulse when a complete frame is committed.

Function
REQ-009 Capture: sync_in=1 in cycle t SHALL store nib_in as nibble 0; nibbles 1, 2, 3 SHALL be taken from cycles t+1, t+2, t+3.
REQ-010 On the edge ending cycle t+3, disp_buf[15:0] SHALL be loaded with {nib3, nib2, nib1, nib0} atomically; frame_valid SHALL be 1 in cycle t+4 only.
REQ-011 After nibble 3, capture SHALL idle and ignore nib_in until the next sync_in.
REQ-012 sync_in during t+1..t+3 SHALL discard the partial frame, leave disp_buf unchanged, and restart capture with that cycle as nibble 0.
REQ-013 sync_in in cycle t+4 (back-to-back frames) SHALL start a new frame with no lost cycle.
REQ-014 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, digit index SHALL advance 0->1->2->3->0.
REQ-015 an_n and seg_n SHALL be registered, reflecting the digit index and disp_buf one cycle after either changes.
REQ-016 seg_n SHALL be the hex decode of disp_buf[4k+3:4k] for the lit digit k, covering 0-9 and A-F.
REQ-017 Encodings (active-low): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110.
REQ-018 A disp_buf commit mid-dwell SHALL show on the current digit from the next cycle, without restarting the prescaler.

Reset
REQ-019 Reset SHALL clear disp_buf, capture nibbles, prescaler and digit index to 0, and set capture to idle.
REQ-020 Reset values SHALL be: an_n=1111, seg_n=1111111, frame_valid=0.
REQ-021 Reset mid-frame SHALL discard the partial frame; the first clock after release SHALL light digit 0 showing "0".

Configuration
REQ-022 With DISP_LZB_EN defined: digit k (k=3..1) SHALL be blanked (seg_n=1111111, an_n unchanged) when it and all higher digits are 0; digit 0 SHALL never be blanked.
REQ-023 Without DISP_LZB_EN: every digit SHALL show its hex value, zeros included.

Structure
REQ-024 A shared package SHALL hold the segment encoding constants, the blank pattern (7'h7F) and the digit-count constant (4).
REQ-025 Hex-to-segment decoding SHALL be a combinational sub-module hex7seg (4-bit in, 7-bit active-low out), instantiated once.

Verification (REFRESH_DIV=4)
REQ-026 Stream 0,1,2,3 with sync on 0 -> disp_buf=16'h3210, frame_valid pulse at t+4, digits 0..3 show 0,1,2,3, each lit 4 cycles.
REQ-027 Sync at t, nibbles 5,6, then sync at t+2 followed by A,B,C,D -> no commit for the partial frame; disp_buf=16'hDCBA.
REQ-028 Continuous frames 16'h00F0 then 16'h0008 back-to-back -> two frame_valid pulses 4 cycles apart; final disp_buf=16'h0008.
REQ-029 disp_buf=16'h0008 -> with DISP_LZB_EN, digits 3..1 blank and digit 0 = 0000000; without it, digits 3..1 = 1000000.
REQ-030 Reset asserted at t+2 of a frame of 16'hFFFF -> outputs at reset values, disp_buf=0, no frame_valid pulse.
REQ-031 Commit of 16'hAAAA during digit 2 dwell -> seg_n=0001000 the cycle after commit; digit 2 dwell length unchanged.

Source files
------------

// File: rtl/seg_scanner_pkg.sv
// Shared constants for the 4-digit seven-segment scanner: segment encodings,
// blank pattern, digit count and the capture state type.
package seg_scanner_pkg;

  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
  localparam int unsigned BUF_W      = NIB_W * NUM_DIGITS;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

  // Capture state names the next nibble expected after nibble 0
  typedef enum logic [1:0] {
    CAP_IDLE = 2'd0,
    CAP_NIB1 = 2'd1,
    CAP_NIB2 = 2'd2,
    CAP_NIB3 = 2'd3
  } cap_state_t;

endpackage

// File: rtl/seg_scanner_hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex7seg
  import seg_scanner_pkg::*;
(
  input  logic [NIB_W-1:0] hex,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (hex)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      default: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_scanner.sv
// Serial nibble capture into a 4-digit display buffer with multiplexed scan.
// Define DISP_LZB_EN to blank leading-zero digits (digit 0 always shown).
module seg_scanner
  import seg_scanner_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] nib_in,
  input  logic       sync_in,
  output logic [6:0] seg_n,
  output logic [3:0] an_n,
  output logic       frame_valid
);

  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);

  cap_state_t       cap_state, cap_state_nxt;
  logic             commit_c;
  logic [NIB_W-1:0] nib0, nib1, nib2;
  logic [BUF_W-1:0] disp_buf;
  logic [PRE_W-1:0] pre_cnt;
  logic [DIG_W-1:0] dig_idx;
  logic [NIB_W-1:0] cur_nib_c;
  logic [SEG_W-1:0] dec_seg_c;
  logic             blank_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cap_state <= CAP_IDLE;
    else       cap_state <= cap_state_nxt;
  end

  // A sync always restarts the frame, discarding any partial capture
  always_comb begin
    cap_state_nxt = cap_state;
    commit_c      = 1'b0;
    if (sync_in) begin
      cap_state_nxt = CAP_NIB1;
    end else begin
      case (cap_state)
        CAP_NIB1: cap_state_nxt = CAP_NIB2;
        CAP_NIB2: cap_state_nxt = CAP_NIB3;
        CAP_NIB3: begin
          cap_state_nxt = CAP_IDLE;
          commit_c      = 1'b1;
        end
        default:  cap_state_nxt = CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nib0        <= '0;
      nib1        <= '0;
      nib2        <= '0;
      disp_buf    <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (sync_in) begin
        nib0 <= nib_in;
      end else begin
        case (cap_state)
          CAP_NIB1: nib1 <= nib_in;
          CAP_NIB2: nib2 <= nib_in;
          default: ;
        endcase
      end
      if (commit_c) disp_buf <= {nib_in, nib2, nib1, nib0};
      frame_valid <= commit_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      dig_idx <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
      dig_idx <= dig_idx + DIG_W'(1);
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  assign cur_nib_c = disp_buf[NIB_W*32'(dig_idx) +: NIB_W];

  hex7seg u_hex7seg (
    .hex   (cur_nib_c),
    .seg_c (dec_seg_c)
  );

`ifdef DISP_LZB_EN
  // Digit k is blanked when it and every higher digit are zero
  always_comb begin
    blank_c = 1'b0;
    case (dig_idx)
      2'd1:    blank_c = (disp_buf[BUF_W-1:NIB_W]   == '0);
      2'd2:    blank_c = (disp_buf[BUF_W-1:2*NIB_W] == '0);
      2'd3:    blank_c = (disp_buf[BUF_W-1:3*NIB_W] == '0);
      default: blank_c = 1'b0;
    endcase
  end
`else
  assign blank_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n  <= '1;
      seg_n <= SEG_BLANK;
    end else begin
      an_n  <= ~(NUM_DIGITS'(1) << dig_idx);
      seg_n <= blank_c ? SEG_BLANK : dec_seg_c;
    end
  end

endmodule

// File: tb/tb_seg_scanner.sv
// Scoreboard bench for seg_scanner at REFRESH_DIV=4; honours DISP_LZB_EN.
module tb_seg_scanner;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] nib_in = 4'h0;
  logic       sync_in = 1'b0;
  logic [6:0] seg_n;
  logic [3:0] an_n;
  logic       frame_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fv_last = -100;
  int fv_prev = -100;
  logic [15:0] exp_q[$];

  seg_scanner #(.REFRESH_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .nib_in      (nib_in),
    .sync_in     (sync_in),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [6:0] hex_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
    logic [15:0] hi;
    hi = v >> (4 * k);
`ifdef DISP_LZB_EN
    if (k > 0 && hi == 16'h0) return 7'b1111111;
`endif
    return hex_seg(hi[3:0]);
  endfunction

  // Commits are checked against the scoreboard as frame_valid pulses
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      fv_prev = fv_last;
      fv_last = cyc;
      if (exp_q.size() == 0) check("fv_spurious", 32'(frame_valid), 32'd0);
      else check("disp_buf", 32'(dut.disp_buf), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is at posedge+1; returns at posedge+1 of cycle t+4
  task automatic send_frame(input logic [15:0] v, input bit push);
    if (push) exp_q.push_back(v);
    sync_in = 1'b1; nib_in = v[3:0];   tick();
    sync_in = 1'b0; nib_in = v[7:4];   tick();
    nib_in = v[11:8];                  tick();
    nib_in = v[15:12];                 tick();
    nib_in = 4'h0;
  endtask

  task automatic find_digit(input int k, output bit found);
    logic [3:0] tgt, prev;
    tgt = ~(4'b0001 << k);
    found = 1'b0;
    prev = an_n;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an_n == tgt && prev != tgt) found = 1'b1;
      prev = an_n;
    end
    if (!found) check("find_digit_timeout", 32'd0, 32'd1);
  endtask

  task automatic scan_digits(input logic [15:0] v);
    bit found;
    int n;
    logic [3:0] tgt;
    find_digit(0, found);
    if (!found) return;
    for (int k = 0; k < 4; k++) begin
      tgt = ~(4'b0001 << k);
      check($sformatf("an_n_d%0d", k), 32'(an_n), 32'(tgt));
      check($sformatf("seg_n_%h_d%0d", v, k), 32'(seg_n), 32'(exp_seg(v, k)));
      n = 0;
      while (an_n == tgt && n < 20) begin
        n++;
        @(negedge clk);
      end
      check($sformatf("dwell_d%0d", k), 32'(n), 32'd4);
    end
  endtask

  initial begin
    bit found;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_an_n", 32'(an_n), 32'hF);
    check("rst_seg_n", 32'(seg_n), 32'h7F);
    check("rst_fv", 32'(frame_valid), 32'd0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_an_n", 32'(an_n), 32'hE);
    check("post_rst_seg_n", 32'(seg_n), 32'(hex_seg(4'h0)));

    // Basic frame 3210
    tick();
    send_frame(16'h3210, 1'b1);
    scan_digits(16'h3210);

    // Partial frame 5,6 aborted by a new sync
    tick();
    sync_in = 1'b1; nib_in = 4'h5; tick();
    sync_in = 1'b0; nib_in = 4'h6; tick();
    send_frame(16'hDCBA, 1'b1);
    repeat (3) tick();
    check("abort_disp", 32'(dut.disp_buf), 32'h0000DCBA);

    // Back-to-back frames
    send_frame(16'h00F0, 1'b1);
    send_frame(16'h0008, 1'b1);
    repeat (2) tick();
    check("b2b_spacing", 32'(fv_last - fv_prev), 32'd4);
    scan_digits(16'h0008);

    // Commit of AAAA landing mid-dwell on digit 2
    find_digit(1, found);
    if (found) begin
      tick();
      send_frame(16'hAAAA, 1'b1);
      @(negedge clk);
      check("mid_fv", 32'(frame_valid), 32'd1);
      check("mid_an_c1", 32'(an_n), 32'hB);
      check("mid_seg_old", 32'(seg_n), 32'(exp_seg(16'h0008, 2)));
      @(negedge clk);
      check("mid_an_c2", 32'(an_n), 32'hB);
      check("mid_seg_new", 32'(seg_n), 32'h08);
      @(negedge clk);
      check("mid_an_c3", 32'(an_n), 32'hB);
      @(negedge clk);
      check("mid_an_next", 32'(an_n), 32'h7);
    end

    // Reset in the middle of a FFFF frame
    tick();
    sync_in = 1'b1; nib_in = 4'hF; tick();
    sync_in = 1'b0; tick();
    reset = 1'b1;
    @(negedge clk);
    check("mrst_an_n", 32'(an_n), 32'hF);
    check("mrst_seg_n", 32'(seg_n), 32'h7F);
    check("mrst_fv", 32'(frame_valid), 32'd0);
    check("mrst_disp", 32'(dut.disp_buf), 32'd0);
    repeat (3) tick();
    nib_in = 4'h0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mrst_rel_an_n", 32'(an_n), 32'hE);
    check("mrst_rel_seg_n", 32'(seg_n), 32'(hex_seg(4'h0)));
    repeat (8) @(negedge clk);
    check("mrst_no_fv", 32'(frame_valid), 32'd0);
    check("mrst_disp_hold", 32'(dut.disp_buf), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
